// File: rtl/pe_pkt_pkg.sv
// Shared packet field layout, opcodes and transmitter state encoding for the
// PE packet interface.
package pe_pkt_pkg;

    localparam int unsigned ADDR_START   = 32;
    localparam int unsigned ADDR_END     = 29;
    localparam int unsigned OPCODE_START = 28;
    localparam int unsigned OPCODE_END   = 25;
    localparam int unsigned DATA_START   = 24;
    localparam int unsigned DATA_END     = 0;

    localparam logic [3:0] OPC_WEIGHT = 4'd0;
    localparam logic [3:0] OPC_INPUT  = 4'd1;

    typedef logic [32:0] pkt_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_W0,
        SEND_W1,
        SEND_IN,
        GAP
    } tx_state_t;

    function automatic pkt_t make_pkt(input logic [3:0] addr,
                                      input logic [3:0] opcode,
                                      input logic [24:0] data);
        pkt_t p;
        p = '0;
        p[ADDR_START:ADDR_END]     = addr;
        p[OPCODE_START:OPCODE_END] = opcode;
        p[DATA_START:DATA_END]     = data;
        return p;
    endfunction

endpackage

// File: rtl/pe_pkt_fmt.sv
// Combinational packet formatter: builds the packet that belongs to a given
// transmitter state from the captured command fields.
module pe_pkt_fmt
    import pe_pkt_pkg::*;
(
    input  tx_state_t    state,
    input  logic [3:0]   addr,
    input  logic [39:0]  weights,
    input  logic [24:0]  spikes,
    output pkt_t         pkt
);

    always_comb begin
        pkt = '0;
        case (state)
            SEND_W0: pkt = make_pkt(addr, OPC_WEIGHT,
                                    {1'b0, weights[23:16], weights[15:8], weights[7:0]});
            // Upper weight byte slot is unused by the PE and driven to zero.
            SEND_W1: pkt = make_pkt(addr, OPC_WEIGHT,
                                    {9'b0, weights[39:32], weights[31:24]});
            SEND_IN: pkt = make_pkt(addr, OPC_INPUT, spikes);
            default: pkt = '0;
        endcase
    end

endmodule

// File: rtl/pe_packet_tx.sv
// PE packet transmitter: accepts one weight-row or spike-row command and emits
// the corresponding packet(s) over a valid/ready interface with optional pacing.
module pe_packet_tx
    import pe_pkt_pkg::*;
#(
    parameter int unsigned PKT_W      = 33,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_type,
    input  logic [3:0]        cmd_addr,
    input  logic [39:0]       cmd_weights,
    input  logic [24:0]       cmd_spikes,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [PKT_W-1:0]  pkt_data,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_count
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    tx_state_t   state, state_next;
    tx_state_t   ret_state, ret_next;
    logic [7:0]  gap_cnt, gap_next;

    logic [3:0]  addr_q;
    logic [39:0] weights_q;
    logic [24:0] spikes_q;

    logic        accept;
    logic        xfer;
    logic [3:0]  fmt_addr;
    logic [39:0] fmt_weights;
    logic [24:0] fmt_spikes;
    pkt_t        fmt_pkt;

    assign accept = cmd_valid & (state == IDLE);
    assign xfer   = pkt_valid & pkt_ready;

    always_comb begin
        state_next = state;
        ret_next   = ret_state;
        gap_next   = gap_cnt;
        case (state)
            IDLE: begin
                if (cmd_valid) state_next = cmd_type ? SEND_IN : SEND_W0;
            end
            SEND_W0: begin
                if (pkt_ready) begin
                    if (GAP_CYCLES == 0) begin
                        state_next = SEND_W1;
                    end else begin
                        state_next = GAP;
                        ret_next   = SEND_W1;
                        gap_next   = '0;
                    end
                end
            end
            SEND_W1, SEND_IN: begin
                if (pkt_ready) begin
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = GAP;
                        ret_next   = IDLE;
                        gap_next   = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_next = ret_state;
                else                     gap_next   = gap_cnt + 8'd1;
            end
            default: state_next = IDLE;
        endcase
    end

    // The formatter looks one cycle ahead (next state, freshly accepted fields)
    // so pkt_data is a plain register aligned with pkt_valid.
    always_comb begin
        fmt_addr    = addr_q;
        fmt_weights = weights_q;
        fmt_spikes  = spikes_q;
        if (accept) begin
            fmt_addr    = cmd_addr;
            fmt_weights = cmd_weights;
            fmt_spikes  = cmd_spikes;
        end
    end

    pe_pkt_fmt u_fmt (
        .state   (state_next),
        .addr    (fmt_addr),
        .weights (fmt_weights),
        .spikes  (fmt_spikes),
        .pkt     (fmt_pkt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ret_state <= IDLE;
            gap_cnt   <= '0;
            addr_q    <= '0;
            weights_q <= '0;
            spikes_q  <= '0;
        end else begin
            state     <= state_next;
            ret_state <= ret_next;
            gap_cnt   <= gap_next;
            if (accept) begin
                addr_q    <= cmd_addr;
                weights_q <= cmd_weights;
                spikes_q  <= cmd_spikes;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            pkt_valid <= (state_next == SEND_W0) || (state_next == SEND_W1) ||
                         (state_next == SEND_IN);
            pkt_data  <= PKT_W'(fmt_pkt);
            busy      <= (state_next != IDLE);
            cmd_ready <= (state_next == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    pkt_count <= '0;
        else if (xfer) pkt_count <= pkt_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_pe_packet_tx.sv
// Self-checking bench for pe_packet_tx: one unpaced instance and one paced,
// narrow-counter instance, each with a packet scoreboard.
module tb_pe_packet_tx;

    logic        clk;
    logic        rst_n;

    logic        cmd_valid, cmd_ready, cmd_type;
    logic [3:0]  cmd_addr;
    logic [39:0] cmd_weights;
    logic [24:0] cmd_spikes;
    logic        pkt_valid, pkt_ready, busy;
    logic [32:0] pkt_data;
    logic [15:0] pkt_count;

    logic        a_cmd_valid, a_cmd_ready, a_cmd_type;
    logic [3:0]  a_cmd_addr;
    logic [39:0] a_cmd_weights;
    logic [24:0] a_cmd_spikes;
    logic        a_pkt_valid, a_pkt_ready, a_busy;
    logic [32:0] a_pkt_data;
    logic [3:0]  a_pkt_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    logic [32:0] exp_q[$];
    logic [32:0] a_exp_q[$];

    typedef struct {
        logic        ctype;
        logic [3:0]  addr;
        logic [39:0] w;
        logic [24:0] s;
        logic [32:0] exp0;
        logic [32:0] exp1;
    } vec_t;
    vec_t vecs[6];

    pe_packet_tx #(.PKT_W(33), .GAP_CYCLES(0), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_addr(cmd_addr), .cmd_weights(cmd_weights), .cmd_spikes(cmd_spikes),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data),
        .busy(busy), .pkt_count(pkt_count)
    );

    pe_packet_tx #(.PKT_W(33), .GAP_CYCLES(4), .CNT_W(4)) u_alt (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_type(a_cmd_type),
        .cmd_addr(a_cmd_addr), .cmd_weights(a_cmd_weights), .cmd_spikes(a_cmd_spikes),
        .pkt_valid(a_pkt_valid), .pkt_ready(a_pkt_ready), .pkt_data(a_pkt_data),
        .busy(a_busy), .pkt_count(a_pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshakes are sampled on the falling edge, half a cycle before the
    // rising edge that completes them.
    task automatic monitor_main();
        forever begin
            @(negedge clk);
            if (rst_n && pkt_valid && pkt_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL main_extra_pkt: got 0x%0h, expected no packet", pkt_data);
                end else begin
                    chk("main_pkt", 64'(pkt_data), 64'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic monitor_alt();
        forever begin
            @(negedge clk);
            if (rst_n && a_pkt_valid && a_pkt_ready) begin
                if (a_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL alt_extra_pkt: got 0x%0h, expected no packet", a_pkt_data);
                end else begin
                    chk("alt_pkt", 64'(a_pkt_data), 64'(a_exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic send_main(input logic t, input logic [3:0] a,
                             input logic [39:0] w, input logic [24:0] s);
        int n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("main_cmd_ready_before_send", 64'(cmd_ready), 64'd1);
        cmd_valid   = 1'b1;
        cmd_type    = t;
        cmd_addr    = a;
        cmd_weights = w;
        cmd_spikes  = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_main_idle(input string name);
        int n = 0;
        while ((!cmd_ready || exp_q.size() != 0) && n < 100) begin tick(); n++; end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_alt_idle(input string name);
        int n = 0;
        while ((!a_cmd_ready || a_exp_q.size() != 0) && n < 200) begin tick(); n++; end
        chk(name, 64'(a_exp_q.size()), 64'd0);
    endtask

    initial begin
        int lat;
        int acc;
        int n;

        vecs[0] = '{1'b0, 4'd5,  40'h0504030201, 25'h1555555, 33'h0A0030201, 33'h0A0000504};
        vecs[1] = '{1'b1, 4'd5,  40'hFFFFFFFFFF, 25'h0AAAAAA, 33'h0A2AAAAAA, 33'h0};
        vecs[2] = '{1'b0, 4'd15, 40'hFFFFFFFFFF, 25'h1FFFFFF, 33'h1E0FFFFFF, 33'h1E000FFFF};
        vecs[3] = '{1'b1, 4'd0,  40'h123456789A, 25'h1FFFFFF, 33'h003FFFFFF, 33'h0};
        vecs[4] = '{1'b0, 4'd3,  40'hA1B2C3D4E5, 25'h0000001, 33'h060C3D4E5, 33'h06000A1B2};
        vecs[5] = '{1'b1, 4'd10, 40'h0000000000, 25'h1234567, 33'h143234567, 33'h0};

        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_type = 1'b0; cmd_addr = '0; cmd_weights = '0; cmd_spikes = '0;
        pkt_ready = 1'b0;
        a_cmd_valid = 1'b0; a_cmd_type = 1'b0; a_cmd_addr = '0; a_cmd_weights = '0; a_cmd_spikes = '0;
        a_pkt_ready = 1'b0;

        fork
            monitor_main();
            monitor_alt();
        join_none

        // Reset state
        tick();
        tick();
        chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
        chk("rst_pkt_data",  64'(pkt_data),  64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_alt_count", 64'(a_pkt_count), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // pkt_ready while idle has no effect
        pkt_ready = 1'b1;
        repeat (3) tick();
        chk("idle_ready_count", 64'(pkt_count), 64'd0);
        chk("idle_ready_valid", 64'(pkt_valid), 64'd0);

        // Table-driven commands with pkt_ready held high
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp0);
            exp_count++;
            if (!vecs[i].ctype) begin
                exp_q.push_back(vecs[i].exp1);
                exp_count++;
            end
            send_main(vecs[i].ctype, vecs[i].addr, vecs[i].w, vecs[i].s);
            chk($sformatf("vec%0d_valid", i), 64'(pkt_valid), 64'd1);
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
            lat = 0;
            while (!cmd_ready && lat < 20) begin tick(); lat++; end
            chk($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].ctype ? 64'd1 : 64'd2);
            chk($sformatf("vec%0d_queue", i), 64'(exp_q.size()), 64'd0);
            chk($sformatf("vec%0d_count", i), 64'(pkt_count), 64'(16'(exp_count)));
        end

        // Backpressure on W0
        pkt_ready = 1'b0;
        send_main(1'b0, 4'd5, 40'h0504030201, 25'h0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), 64'(pkt_valid), 64'd1);
            chk($sformatf("bp_data_%0d", k),  64'(pkt_data),  64'h0A0030201);
            chk($sformatf("bp_count_%0d", k), 64'(pkt_count), 64'(16'(exp_count)));
            tick();
        end
        exp_q.push_back(33'h0A0030201);
        exp_q.push_back(33'h0A0000504);
        exp_count += 2;
        pkt_ready = 1'b1;
        wait_main_idle("bp_drain");
        chk("bp_count_final", 64'(pkt_count), 64'(16'(exp_count)));

        // Reset while holding the W1 packet
        pkt_ready = 1'b0;
        send_main(1'b0, 4'd5, 40'h0504030201, 25'h0);
        exp_q.push_back(33'h0A0030201);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
        chk("midrst_w1_valid", 64'(pkt_valid), 64'd1);
        chk("midrst_w1_data",  64'(pkt_data),  64'h0A0000504);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(pkt_valid), 64'd0);
        chk("midrst_count", 64'(pkt_count), 64'd0);
        exp_count = 0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        pkt_ready = 1'b1;
        repeat (5) tick();
        chk("midrst_no_w1", 64'(pkt_count), 64'd0);
        chk("midrst_queue", 64'(exp_q.size()), 64'd0);

        // Paced instance: 4 idle cycles after each packet
        a_pkt_ready = 1'b1;
        a_exp_q.push_back(33'h0C0334455);
        a_exp_q.push_back(33'h0C0001122);
        chk("gap_cmd_ready", 64'(a_cmd_ready), 64'd1);
        a_cmd_valid = 1'b1;
        a_cmd_type = 1'b0;
        a_cmd_addr = 4'd6;
        a_cmd_weights = 40'h1122334455;
        a_cmd_spikes = 25'h1FFFFFF;
        tick();
        a_cmd_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            chk($sformatf("gap_valid_%0d", k), 64'(a_pkt_valid), (k == 0 || k == 5) ? 64'd1 : 64'd0);
            chk($sformatf("gap_ready_%0d", k), 64'(a_cmd_ready), (k == 10) ? 64'd1 : 64'd0);
            chk($sformatf("gap_busy_%0d", k),  64'(a_busy),      (k < 10) ? 64'd1 : 64'd0);
            tick();
        end
        chk("gap_queue", 64'(a_exp_q.size()), 64'd0);
        chk("gap_count", 64'(a_pkt_count), 64'd2);

        // Counter wrap with cmd_valid held continuously
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        a_cmd_type = 1'b1;
        a_cmd_addr = 4'd9;
        a_cmd_weights = 40'hFFFFFFFFFF;
        a_cmd_valid = 1'b1;
        acc = 0;
        n = 0;
        while (acc < 17 && n < 1000) begin
            if (a_cmd_ready) begin
                a_cmd_spikes = 25'(acc * 37 + 3);
                a_exp_q.push_back({4'd9, 4'd1, 25'(acc * 37 + 3)});
                acc++;
            end
            tick();
            n++;
        end
        a_cmd_valid = 1'b0;
        chk("wrap_accepted", 64'(acc), 64'd17);
        wait_alt_idle("wrap_drain");
        chk("wrap_count", 64'(a_pkt_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_packet_tx.md
Name: pe_packet_tx

Overview:
- Clocked packet transmitter that feeds the PE mesh with the same 33-bit packet format the PPE receives.
- Accepts one command per transaction: either a 5-weight filter row or a 25-bit input spike row.
- Formats each command into weight packets (opcode 0) or an input packet (opcode 1), addressed to a target PE.
- Sits between the memory/loader and the PE injection port; it is the sending end of the PE packet interface.

Parameters:
- PKT_W, 33, packet width.
- GAP_CYCLES, 0, idle cycles inserted after every accepted packet (pacing, 0..255).
- CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_type  in  1  0 = weight row, 1 = input row.
- cmd_addr  in  4  destination PE ID.
- cmd_weights  in  40  w0..w4, 8 bits each; w0 in [7:0], w4 in [39:32].
- cmd_spikes  in  25  spike bits, bit i = input i.
- pkt_valid  out  1  packet offered downstream.
- pkt_ready  in  1  downstream accepts.
- pkt_data  out  33  [32:29] addr, [28:25] opcode, [24:0] data.
- busy  out  1  state != IDLE.
- pkt_count  out  CNT_W  packets handshaken since reset; wraps to 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pkt_valid=0; pkt_data=0; pkt_count=0; busy=0; cmd_ready=1 once reset is released.
  - Any in-flight command is dropped. The gap counter clears.
- cmd_ready = (state==IDLE). A command is accepted on a rising edge where cmd_valid & cmd_ready; its fields are captured into registers.
- States: IDLE, SEND_W0, SEND_W1, SEND_IN, GAP.
  - IDLE -> SEND_W0 when the accepted cmd_type=0.
  - IDLE -> SEND_IN when the accepted cmd_type=1.
  - SEND_W0 on handshake -> SEND_W1 if GAP_CYCLES=0; otherwise -> GAP with return state SEND_W1.
  - SEND_W1 / SEND_IN on handshake -> IDLE if GAP_CYCLES=0; otherwise -> GAP with return state IDLE.
  - GAP counts GAP_CYCLES cycles, then goes to the return state.
- Outputs are registered; there is no combinational path from cmd_* or pkt_ready to any output.
  - pkt_valid=1 exactly in the SEND_* states; first asserted the cycle after command acceptance.
- Packet formats:
  - W0 packet: opcode 0; [23:16]=w2, [15:8]=w1, [7:0]=w0; [24]=0.
  - W1 packet: opcode 0; [23:16]=0 (don't-care at the PE, driven 0), [15:8]=w4, [7:0]=w3; [24]=0.
  - IN packet: opcode 1; [24:0]=spikes.
  - addr = captured cmd_addr in every packet.
- Handshake: once pkt_valid rises, pkt_valid and pkt_data hold stable until the edge where pkt_ready=1. A transfer occurs on that edge and pkt_count increments by 1.
- Throughput with GAP_CYCLES=0 and pkt_ready held high:
  - Weight command: packets on cycles N+1 and N+2; cmd_ready high again on N+3.
  - Input command: packet on N+1; cmd_ready on N+2.
- Boundaries:
  - pkt_ready high while pkt_valid low has no effect.
  - cmd_valid while busy is ignored and must be held by the source.
  - pkt_count wraps from 2^CNT_W-1 to 0.
  - Reset asserted mid-packet drops pkt_valid immediately (asynchronously).

Decomposition:
- Package pe_pkt_pkg holds:
  - Field constants: ADDR_START=32, ADDR_END=29, OPCODE_START=28, OPCODE_END=25, DATA_START=24, DATA_END=0.
  - OPC_WEIGHT=4'd0, OPC_INPUT=4'd1.
  - typedef pkt_t (logic [32:0]).
  - State enum tx_state_t.
- One combinational sub-module, pe_pkt_fmt: inputs are state, addr, weights and spikes; output is pkt_t. pkt_data registers the output of pe_pkt_fmt. The FSM, gap counter and packet counter live in the top level.

Test Plan:
1. Weight cmd: addr=5, w0..w4=1,2,3,4,5, pkt_ready=1, GAP=0 -> pkt_data 0x0A0030201 then 0x0A0000504 on consecutive cycles; pkt_count=2.
2. Input cmd: addr=5, spikes=0x0AAAAAA (bit i = i%2) -> single packet 0x0A2AAAAAA; cmd_ready returns 1 cycle after the handshake.
3. Backpressure: pkt_ready=0 for 5 cycles during W0 -> pkt_valid=1 and pkt_data=0x0A0030201 stable all 5 cycles; pkt_count unchanged until pkt_ready=1.
4. GAP_CYCLES=4, weight cmd, pkt_ready=1 -> exactly 4 cycles with pkt_valid=0 between the W0 and W1 handshakes; cmd_ready=0 during the gap.
5. Reset mid-op: drop rst_n during SEND_W1 -> pkt_valid=0 and pkt_count=0 immediately; after release, busy=0, cmd_ready=1, and the W1 packet is never emitted.
6. Counter wrap with CNT_W=4: send 17 input cmds -> pkt_count reads 1; cmd_valid held during busy is accepted only on return to IDLE, with no duplicate packets.
